// File: rtl/dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_mmio_responder
// Purpose  : Responder end of the core's data-memory port. Ordinary addresses
//            hit a word-addressed RAM; addresses 0xFFFF_xxxx hit an MMIO block
//            with a free-running cycle counter and a transmit FIFO drained
//            over a valid/ready stream. Reads are combinational, writes
//            commit on the rising edge of clk.
// Ports    : clk        - system clock
//            reset      - asynchronous active-high reset
//            dmem_we    - write enable from the core
//            dmem_addr  - byte address (bits [1:0] ignored)
//            dmem_wdata - write data
//            dmem_rdata - combinational read data
//            out_valid  - FIFO head valid
//            out_data   - FIFO head word (0 when empty)
//            out_ready  - downstream accepts the head word
// Revision : 1.0 - initial release
// ============================================================================
module dmem_mmio_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);

  localparam int c_RAM_AW = $clog2(RAM_WORDS);
  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [c_PTR_W:0] c_FULL_COUNT = (c_PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [7:0] c_OFF_TXDATA = 8'h00;
  localparam logic [7:0] c_OFF_STATUS = 8'h04;
  localparam logic [7:0] c_OFF_CYCLE  = 8'h08;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic                w_is_mmio;
  logic [c_RAM_AW-1:0] w_ram_idx;
  logic [7:0]          w_off;
  logic                w_unused;

  assign w_is_mmio = (dmem_addr[31:16] == 16'hFFFF);
  assign w_ram_idx = dmem_addr[c_RAM_AW+1:2];
  assign w_off     = dmem_addr[7:0];
  // Offset bits [15:8] and the byte lane bits are deliberately don't-care.
  assign w_unused  = ^{dmem_addr[15:8], dmem_addr[1:0]};

  logic w_ram_we;
  logic w_push_req;
  logic w_status_clr;
  logic w_cycle_ld;

  assign w_ram_we     = dmem_we && !w_is_mmio;
  assign w_push_req   = dmem_we && w_is_mmio && (w_off == c_OFF_TXDATA);
  assign w_status_clr = dmem_we && w_is_mmio && (w_off == c_OFF_STATUS) && dmem_wdata[2];
  assign w_cycle_ld   = dmem_we && w_is_mmio && (w_off == c_OFF_CYCLE);

  // --------------------------------------------------------------------------
  // RAM (contents survive reset, so no reset term here)
  // --------------------------------------------------------------------------
  logic [31:0] r_ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[w_ram_idx] <= dmem_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Transmit FIFO
  // --------------------------------------------------------------------------
  logic [31:0]        r_fifo [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               r_overflow;
  logic [31:0]        r_cycle;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL_COUNT);
  assign w_pop   = !w_empty && out_ready;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign w_push  = w_push_req && (!w_full || w_pop);
  assign w_drop  = w_push_req && w_full && !w_pop;

  // Storage needs no reset: the cleared count makes stale entries invisible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= dmem_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_cycle    <= '0;
    end else begin
      // Pointers are power-of-two wide, so they wrap naturally.
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Clear has priority over a coincident overflow event.
      if (w_status_clr) begin
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end

      if (w_cycle_ld) begin
        r_cycle <= dmem_wdata;
      end else begin
        r_cycle <= r_cycle + 32'd1;
      end
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? 32'd0 : r_fifo[r_rd_ptr];

  // --------------------------------------------------------------------------
  // Combinational read path
  // --------------------------------------------------------------------------
  always_comb begin
    dmem_rdata = 32'd0;
    if (w_is_mmio) begin
      unique case (w_off)
        c_OFF_STATUS: dmem_rdata = {29'd0, r_overflow, w_full, w_empty};
        c_OFF_CYCLE:  dmem_rdata = r_cycle;
        default:      dmem_rdata = 32'd0;
      endcase
    end else begin
      dmem_rdata = r_ram[w_ram_idx];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_mmio_responder
// Purpose  : Self-checking bench for dmem_mmio_responder. A queue/array
//            reference model tracks RAM, FIFO, overflow flag and counter; a
//            compare process checks every falling edge, and directed
//            sequences pin the model with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_mmio_responder;

  localparam int RAM_WORDS  = 64;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dmem_we = 1'b0;
  logic [31:0] dmem_addr = 32'd0;
  logic [31:0] dmem_wdata = 32'd0;
  logic [31:0] dmem_rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;

  always #5 clk = ~clk;

  dmem_mmio_responder #(
    .RAM_WORDS (RAM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  logic [31:0] m_ram [RAM_WORDS];
  bit          m_known [RAM_WORDS];
  logic [31:0] m_q [$];
  logic [31:0] m_cycle;
  bit          m_ovf;

  initial begin
    for (int i = 0; i < RAM_WORDS; i++) m_known[i] = 1'b0;
  end

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:16] == 16'hFFFF;
  endfunction

  function automatic int ram_index(input logic [31:0] a);
    return int'(a[31:2]) % RAM_WORDS;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_cycle = 32'd0;
      m_ovf   = 1'b0;
    end else begin
      automatic bit mm  = is_mmio(dmem_addr);
      automatic int off = int'(dmem_addr[7:0]);
      automatic bit pop = (m_q.size() > 0) && out_ready;
      if (pop) void'(m_q.pop_front());
      if (dmem_we && mm && off == 0) begin
        if (m_q.size() < FIFO_DEPTH) m_q.push_back(dmem_wdata);
        else m_ovf = 1'b1;
      end
      if (dmem_we && mm && off == 4 && dmem_wdata[2]) m_ovf = 1'b0;
      if (dmem_we && mm && off == 8) m_cycle = dmem_wdata;
      else m_cycle = m_cycle + 32'd1;
      if (dmem_we && !mm) begin
        m_ram[ram_index(dmem_addr)]   = dmem_wdata;
        m_known[ram_index(dmem_addr)] = 1'b1;
      end
    end
  end

  // Compare process: every falling edge, inputs and outputs are settled.
  always @(negedge clk) begin
    if (checking) begin
      automatic bit          mm  = is_mmio(dmem_addr);
      automatic int          off = int'(dmem_addr[7:0]);
      automatic int          sz  = m_q.size();
      automatic logic [31:0] exp_rd = 32'd0;
      automatic bit          rd_known = 1'b1;
      if (mm) begin
        if (off == 4) exp_rd = {29'd0, m_ovf, (sz == FIFO_DEPTH), (sz == 0)};
        else if (off == 8) exp_rd = m_cycle;
      end else begin
        rd_known = m_known[ram_index(dmem_addr)];
        exp_rd   = m_ram[ram_index(dmem_addr)];
      end
      check("out_valid", {31'd0, out_valid}, {31'd0, sz > 0});
      check("out_data", out_data, (sz > 0) ? m_q[0] : 32'd0);
      if (rd_known) check("dmem_rdata", dmem_rdata, exp_rd);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    dmem_we = 1'b1; dmem_addr = a; dmem_wdata = d;
    step();
    dmem_we = 1'b0;
  endtask

  task automatic rd_lit(input string name, input logic [31:0] a, input logic [31:0] exp);
    dmem_we = 1'b0; dmem_addr = a;
    @(negedge clk);
    check(name, dmem_rdata, exp);
    step();
  endtask

  localparam logic [31:0] A_TX  = 32'hFFFF_0000;
  localparam logic [31:0] A_ST  = 32'hFFFF_0004;
  localparam logic [31:0] A_CYC = 32'hFFFF_0008;
  localparam logic [31:0] A_UNM = 32'hFFFF_0010;

  initial begin
    // Reset and its visible state
    #1 reset = 1'b1;
    checking = 1'b1;
    dmem_addr = A_ST;
    @(negedge clk);
    check("reset_status", dmem_rdata, 32'h1);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Cycle counter after 5 edges
    dmem_addr = A_CYC;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("cycle_5", dmem_rdata, 32'd5);
    step();
    wr(A_CYC, 32'hFFFF_FFFE);
    rd_lit("cycle_load", A_CYC, 32'hFFFF_FFFE);
    step();
    rd_lit("cycle_wrap", A_CYC, 32'h0);

    // RAM and aliasing
    wr(32'h10, 32'hDEAD_BEEF);
    wr(32'h14, 32'h1234_5678);
    rd_lit("ram_10", 32'h10, 32'hDEAD_BEEF);
    rd_lit("ram_14", 32'h14, 32'h1234_5678);
    rd_lit("ram_alias", 32'h110, 32'hDEAD_BEEF);

    // FIFO with stalled output, overflow and clear
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) wr(A_TX, i);
    rd_lit("st_full", A_ST, 32'h2);
    wr(A_TX, 32'd5);
    rd_lit("st_ovf", A_ST, 32'h6);
    wr(A_ST, 32'h4);
    rd_lit("st_clr", A_ST, 32'h2);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("drain_data", out_data, i);
      step();
    end
    dmem_addr = A_ST;
    @(negedge clk);
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("drain_status", dmem_rdata, 32'h1);
    step();

    // Full with simultaneous push and pop
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) wr(A_TX, i);
    out_ready = 1'b1;
    wr(A_TX, 32'd9);
    out_ready = 1'b0;
    rd_lit("pushpop_status", A_ST, 32'h2);
    out_ready = 1'b1;
    begin
      logic [31:0] exp_seq [4] = '{32'd2, 32'd3, 32'd4, 32'd9};
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("pushpop_data", out_data, exp_seq[i]);
        step();
      end
    end
    out_ready = 1'b0;

    // Unmapped MMIO offset
    rd_lit("unmapped_rd", A_UNM, 32'h0);
    wr(A_UNM, 32'hCAFE_F00D);
    rd_lit("unmapped_ram", 32'h10, 32'hDEAD_BEEF);
    rd_lit("unmapped_st", A_ST, 32'h1);

    // Asynchronous reset mid-cycle with entries queued
    for (int i = 0; i < 3; i++) wr(A_TX, 32'hA0 + i);
    #1 reset = 1'b1;
    #1;
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_data", out_data, 32'd0);
    rd_lit("async_status", A_ST, 32'h1);
    rd_lit("async_cycle", A_CYC, 32'h0);
    rd_lit("async_ram", 32'h14, 32'h1234_5678);
    reset = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      automatic int sel = int'($urandom_range(0, 9));
      if (sel < 4) begin
        dmem_addr = $urandom & 32'h0003_FFFC;
      end else begin
        automatic logic [31:0] offs [5] = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h0};
        offs[4] = $urandom & 32'hFF;
        dmem_addr = 32'hFFFF_0000 | (($urandom & 32'hFF) << 8) | offs[$urandom_range(0, 4)];
      end
      dmem_we    = ($urandom_range(0, 1) == 1);
      dmem_wdata = $urandom;
      out_ready  = ($urandom_range(0, 2) == 0);
      step();
    end
    dmem_we = 1'b0;
    step();

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
